// File: rtl/aes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_ctrl_pkg
//  Purpose  : Shared constants for the masked AES round controller: FSM state
//             encodings, round-constant seed and reduction polynomial, and the
//             datapath mux select values.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package aes_ctrl_pkg;

  // FSM state encodings (3-bit, binary)
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_WAIT   = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Round constant seed and GF(2^8) reduction term (x^8 = x^4 + x^3 + x + 1)
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

  // Datapath mux selects for the state and key registers
  localparam logic SEL_LOAD  = 1'b0;  // plaintext / key shares
  localparam logic SEL_ROUND = 1'b1;  // round output / expanded key

endpackage
`default_nettype wire

// File: rtl/aes_rcon_xtime.sv
`default_nettype none
// ============================================================================
//  Module   : aes_rcon_xtime
//  Purpose  : Combinational GF(2^8) multiply-by-x used to step the AES round
//             constant: left shift by one, reduce with 0x1B when the bit
//             shifted out was set.
//  Ports    : din  [7:0] in  - current round constant
//             dout [7:0] out - xtime(din)
//  Revision : 1.0 - initial release
// ============================================================================
module aes_rcon_xtime
  import aes_ctrl_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = {din[6:0], 1'b0} ^ (din[7] ? RCON_POLY : 8'h00);

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_round_ctrl
//  Purpose  : Round sequencer for a masked AES core. Loads plaintext/key
//             shares, then for each of NR rounds waits SBOX_LAT cycles for the
//             round function to settle before latching its output, stepping
//             the round number and round constant. Emits a one-cycle done.
//  Params   : NR       - number of AES rounds (default 10)
//             SBOX_LAT - round-function latency in cycles, 1..15 (default 4)
//  Ports    : clk        in  - clock, rising edge
//             rst_n      in  - synchronous active-low reset
//             start      in  - begin encryption (sampled in IDLE only)
//             abort      in  - cancel run (only with AES_CTRL_ABORT_EN)
//             state_en   out - state register load enable
//             state_sel  out - 0: plaintext shares, 1: round output
//             key_en     out - key register load enable
//             key_sel    out - 0: key shares, 1: expanded key
//             rcon [7:0] out - round constant of the current round
//             round[3:0] out - current round, 1..NR
//             last_round out - current round is NR (MixColumns bypass)
//             busy       out - controller not idle
//             done       out - single-cycle completion pulse
//  Config   : `define AES_CTRL_ABORT_EN adds the abort input and its logic.
//  Revision : 1.0 - initial release
// ============================================================================
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NR       = 10,
  parameter int SBOX_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef AES_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       state_en,
  output logic       state_sel,
  output logic       key_en,
  output logic       key_sel,
  output logic [7:0] rcon,
  output logic [3:0] round,
  output logic       last_round,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] c_ROUND_LAST = 4'(NR);
  // WAIT exits when the counter reads zero, so preload one less than the latency
  localparam logic [3:0] c_WAIT_INIT  = 4'(SBOX_LAT - 1);

  logic [2:0] r_state;
  logic [2:0] w_state_nxt;
  logic [3:0] r_round;
  logic [7:0] r_rcon;
  logic [7:0] w_rcon_nxt;
  logic [3:0] r_wait_cnt;
  logic       w_last;
  logic       w_abort;

`ifdef AES_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_last = (r_round == c_ROUND_LAST);

  aes_rcon_xtime u_xtime (
    .din  (r_rcon),
    .dout (w_rcon_nxt)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) w_state_nxt = ST_LOAD;
        ST_LOAD:   w_state_nxt = ST_WAIT;
        ST_WAIT:   if (r_wait_cnt == 4'd0) w_state_nxt = ST_UPDATE;
        ST_UPDATE: w_state_nxt = w_last ? ST_DONE : ST_WAIT;
        ST_DONE:   w_state_nxt = ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Round counter, round constant and wait counter.
  // Round/rcon are returned to their seed values when the final UPDATE
  // completes, so last_round is only seen in the final WAIT and UPDATE and a
  // following run starts from round 1 without extra logic.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n || w_abort) begin
      r_round    <= 4'd1;
      r_rcon     <= RCON_INIT;
      r_wait_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_round <= 4'd1;
            r_rcon  <= RCON_INIT;
          end
        end
        ST_LOAD: begin
          r_wait_cnt <= c_WAIT_INIT;
        end
        ST_WAIT: begin
          if (r_wait_cnt != 4'd0) r_wait_cnt <= r_wait_cnt - 4'd1;
        end
        ST_UPDATE: begin
          if (w_last) begin
            r_round <= 4'd1;
            r_rcon  <= RCON_INIT;
          end else begin
            r_round    <= r_round + 4'd1;
            r_rcon     <= w_rcon_nxt;
            r_wait_cnt <= c_WAIT_INIT;
          end
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore). Abort only gates the load enables so a cancelled
  // run cannot corrupt the masked registers in the abort cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_en  = 1'b0;
    state_sel = SEL_LOAD;
    key_en    = 1'b0;
    key_sel   = SEL_LOAD;
    busy      = (r_state != ST_IDLE);
    done      = 1'b0;
    case (r_state)
      ST_LOAD: begin
        state_en  = ~w_abort;
        key_en    = ~w_abort;
      end
      ST_UPDATE: begin
        state_en  = ~w_abort;
        state_sel = SEL_ROUND;
        key_en    = ~w_abort;
        key_sel   = SEL_ROUND;
      end
      ST_DONE: begin
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign rcon       = r_rcon;
  assign round      = r_round;
  assign last_round = w_last;

endmodule
`default_nettype wire
